lsu_mem_initiator: RTL and testbench

- Load/store initiator between the core's execute stage and the data memory port; the core side issues one load or store at a time.
- Converts each request into a word-aligned memory transaction with valid/ready request and valid response channels.
- Generates byte strobes and write-data lane placement for stores; performs load lane extraction and sign/zero extension.
- Checks alignment and detects response timeout.

---
 rtl/lsu_mem_initiator.sv | 192 +++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one core load/store at a time into a word-aligned
// valid/ready memory transaction and returns an extended, error-flagged response.
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        is_load_reg, is_load_next;
    logic [2:0]  func3_reg, func3_next;
    logic [1:0]  addr_lo_reg, addr_lo_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic        rsp_err_reg, rsp_err_next;

    logic        op_ok, func3_ok, align_ok, req_legal;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_shifted, ld_data;
    logic [31:0] cnt_inc;
    logic        timeout_hit;

    // Legality is judged on the live request so an illegal one never touches memory.
    always_comb begin
        op_ok = req_is_load ^ req_is_store;
        case (req_func3)
            3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
            3'b100, 3'b101:         func3_ok = req_is_load;
            default:                func3_ok = 1'b0;
        endcase
        case (req_func3[1:0])
            2'b01:   align_ok = ~req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        req_legal = op_ok && func3_ok && align_ok;
    end

    always_comb begin
        case (req_func3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << req_addr[1:0];
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shifted = mem_rsp_rdata >> {addr_lo_reg, 3'b000};
        case (func3_reg)
            3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
            3'b101:  ld_data = {16'd0, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    assign cnt_inc     = cnt_reg + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        is_load_next   = is_load_reg;
        func3_next     = func3_reg;
        addr_lo_next   = addr_lo_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    is_load_next  = req_is_load;
                    func3_next    = req_func3;
                    addr_lo_next  = req_addr[1:0];
                    rsp_data_next = 32'd0;
                    if (req_legal) begin
                        state_next     = REQ;
                        rsp_err_next   = 1'b0;
                        mem_addr_next  = {req_addr[31:2], 2'b00};
                        mem_we_next    = req_is_store;
                        mem_wdata_next = req_is_store ? st_wdata : 32'd0;
                        mem_wstrb_next = req_is_store ? st_wstrb : 4'b0000;
                    end else begin
                        state_next   = RESP;
                        rsp_err_next = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                    cnt_next   = 32'd0;
                end
            end
            WAIT: begin
                cnt_next = cnt_inc;
                // A response arriving on the timeout cycle still counts as success.
                if (mem_rsp_valid) begin
                    state_next    = RESP;
                    rsp_err_next  = 1'b0;
                    rsp_data_next = is_load_reg ? ld_data : 32'd0;
                end else if (timeout_hit) begin
                    state_next    = RESP;
                    rsp_err_next  = 1'b1;
                    rsp_data_next = 32'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 32'd0;
            is_load_reg   <= 1'b0;
            func3_reg     <= 3'd0;
            addr_lo_reg   <= 2'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_wstrb_reg <= 4'd0;
            rsp_data_reg  <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            is_load_reg   <= is_load_next;
            func3_reg     <= func3_next;
            addr_lo_reg   <= addr_lo_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign req_ready     = (state_reg == IDLE);
    assign rsp_valid     = (state_reg == RESP);
    assign rsp_data      = rsp_valid ? rsp_data_reg : 32'd0;
    assign rsp_err       = rsp_valid & rsp_err_reg;
    assign mem_req_valid = (state_reg == REQ);
    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign mem_wstrb     = mem_wstrb_reg;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: vector table of loads/stores driven through a small
// memory responder, responses checked against a scoreboard queue.
module tb_lsu_mem_initiator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_load = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = 32'd0;

    lsu_mem_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;   // -1: memory never answers
        int          rdly;
        logic        legal;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;
    logic [32:0] exp_q[$];
    vec_t vecs[17];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, int waits, int rdly,
                                logic legal, logic err, logic [31:0] data, logic [31:0] maddr,
                                logic [31:0] mwdata, logic [3:0] wstrb);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.rdly = rdly; v.legal = legal; v.exp_err = err; v.exp_data = data;
        v.exp_maddr = maddr; v.exp_mwdata = mwdata; v.exp_wstrb = wstrb;
        return v;
    endfunction

    // Scoreboard consumer: every rsp_valid cycle must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && rsp_valid) begin
            logic [32:0] e;
            rsp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=rsp_valid required=no_rsp");
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e[31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
            $display("rsp: data=%h err=%0d", rsp_data, rsp_err);
        end
    end

    task automatic do_access(input vec_t v);
        int c0;
        int k;
        c0 = rsp_count;
        @(negedge clock);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_load = v.ld; req_is_store = v.st;
        req_func3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        exp_q.push_back({v.exp_err, v.exp_data});
        $display("req: ld=%0d st=%0d f3=%b addr=%h wdata=%h exp_data=%h exp_err=%0d",
                 v.ld, v.st, v.f3, v.addr, v.wdata, v.exp_data, v.exp_err);
        @(posedge clock); #1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        if (!v.legal) begin
            check("illegal_rsp_latency", {31'd0, rsp_valid}, 32'd1);
            check("illegal_no_mem_req", {31'd0, mem_req_valid}, 32'd0);
        end else begin
            check("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
            check("mem_addr", mem_addr, v.exp_maddr);
            check("mem_we", {31'd0, mem_we}, {31'd0, v.st});
            check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
            check("mem_wdata", mem_wdata, v.exp_mwdata);
            for (int i = 0; i < v.rdly; i++) begin
                @(posedge clock); #1;
                check("stall_valid", {31'd0, mem_req_valid}, 32'd1);
                check("stall_addr", mem_addr, v.exp_maddr);
                check("stall_wstrb", {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
                check("stall_wdata", mem_wdata, v.exp_mwdata);
            end
            mem_req_ready = 1'b1;
            @(posedge clock); #1;
            mem_req_ready = 1'b0;
            check("mem_req_valid_drop", {31'd0, mem_req_valid}, 32'd0);
            if (v.waits < 0) begin
                k = 0;
                while (!rsp_valid && k < 40) begin
                    @(posedge clock); #1;
                    k++;
                end
                check("timeout_wait_cycles", k, 32'd8);
            end else begin
                for (int i = 0; i < v.waits; i++) begin
                    @(posedge clock); #1;
                end
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = v.rdata;
                @(posedge clock); #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_rdata = $urandom;
                check("rsp_after_mem_rsp", {31'd0, rsp_valid}, 32'd1);
            end
        end
        k = 0;
        while (rsp_count == c0 && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("rsp_count", rsp_count - c0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1, 0, 3'b010, 32'h80000004, 0, 32'hDEADBEEF, 2, 0, 1, 0, 32'hDEADBEEF, 32'h80000004, 0, 4'b0000);
        vecs[1]  = mk(1, 0, 3'b000, 32'h80000003, 0, 32'h80FF0000, 0, 0, 1, 0, 32'hFFFFFF80, 32'h80000000, 0, 4'b0000);
        vecs[2]  = mk(1, 0, 3'b100, 32'h80000003, 0, 32'h80FF0000, 0, 0, 1, 0, 32'h00000080, 32'h80000000, 0, 4'b0000);
        vecs[3]  = mk(1, 0, 3'b101, 32'h80000002, 0, 32'h80FF0000, 1, 0, 1, 0, 32'h000080FF, 32'h80000000, 0, 4'b0000);
        vecs[4]  = mk(1, 0, 3'b001, 32'h80000002, 0, 32'h80FF0000, 0, 1, 1, 0, 32'hFFFF80FF, 32'h80000000, 0, 4'b0000);
        vecs[5]  = mk(0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 0, 0, 5, 1, 0, 0, 32'h80000000, 32'hABCDABCD, 4'b1100);
        vecs[6]  = mk(0, 1, 3'b000, 32'h80000001, 32'h000000A5, 0, 3, 0, 1, 0, 0, 32'h80000000, 32'hA5A5A5A5, 4'b0010);
        vecs[7]  = mk(0, 1, 3'b010, 32'h80000008, 32'hCAFEF00D, 0, 0, 2, 1, 0, 0, 32'h80000008, 32'hCAFEF00D, 4'b1111);
        vecs[8]  = mk(1, 0, 3'b010, 32'h80000001, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        vecs[9]  = mk(0, 1, 3'b100, 32'h80000000, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        vecs[10] = mk(1, 1, 3'b010, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        vecs[11] = mk(0, 0, 3'b010, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        vecs[12] = mk(1, 0, 3'b001, 32'h80000003, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        vecs[13] = mk(1, 0, 3'b011, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
        vecs[14] = mk(1, 0, 3'b010, 32'h80000020, 0, 0, -1, 0, 1, 1, 0, 32'h80000020, 0, 4'b0000);
        vecs[15] = mk(1, 0, 3'b010, 32'h80000024, 0, 32'h12345678, 7, 0, 1, 0, 32'h12345678, 32'h80000024, 0, 4'b0000);
        vecs[16] = mk(1, 0, 3'b000, 32'h80000000, 0, 32'h1234567F, 0, 0, 1, 0, 32'h0000007F, 32'h80000000, 0, 4'b0000);

        #2;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) do_access(vecs[i]);

        // Stray memory response while idle must be ignored.
        @(negedge clock);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBADBAD00;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        check("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("stray_req_ready", {31'd0, req_ready}, 32'd1);
        $display("stray: mem_rsp_valid in IDLE, rsp_valid=%0d", rsp_valid);

        // Reset asserted while waiting for the memory response.
        begin
            int c0;
            c0 = rsp_count;
            @(negedge clock);
            req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
            req_func3 = 3'b010; req_addr = 32'h80000010;
            @(posedge clock); #1;
            req_valid = 1'b0; req_is_load = 1'b0;
            mem_req_ready = 1'b1;
            @(posedge clock); #1;
            mem_req_ready = 1'b0;
            check("pre_reset_mem_addr", mem_addr, 32'h80000010);
            #2;
            reset_n = 1'b0;
            #1;
            check("midreset_req_ready", {31'd0, req_ready}, 32'd1);
            check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("midreset_rsp_data", rsp_data, 32'd0);
            check("midreset_rsp_err", {31'd0, rsp_err}, 32'd0);
            check("midreset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
            check("midreset_mem_we", {31'd0, mem_we}, 32'd0);
            check("midreset_mem_addr", mem_addr, 32'd0);
            check("midreset_mem_wdata", mem_wdata, 32'd0);
            check("midreset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
            repeat (2) @(posedge clock);
            @(negedge clock);
            reset_n = 1'b1;
            #1;
            check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
            repeat (3) @(posedge clock);
            #1;
            check("aborted_no_rsp", rsp_count - c0, 32'd0);
            $display("reset: mid-WAIT reset applied and released");
        end

        do_access(mk(1, 0, 3'b010, 32'h8000000C, 0, 32'h0BADF00D, 1, 2, 1, 0, 32'h0BADF00D, 32'h8000000C, 0, 4'b0000));

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
